// File: rtl/issue_stage_pkg.sv
// Shared types and constants for the operand-read / issue stage.
// Slot A holds a decoded instruction; slot B holds it with resolved operands.
package issue_stage_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ISSUE_OP_W = 8;
    localparam logic [4:0]  REG_ZERO   = 5'd0;

    typedef struct packed {
        logic [ISSUE_OP_W-1:0] op;
        logic                  rs1_v;
        logic [4:0]            rs1;
        logic                  rs2_v;
        logic [4:0]            rs2;
        logic                  rd_v;
        logic [4:0]            rd;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       pc;
    } issue_slot_t;

    typedef struct packed {
        logic [ISSUE_OP_W-1:0] op;
        logic [XLEN-1:0]       a;
        logic [XLEN-1:0]       b;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       pc;
        logic                  rd_v;
        logic [4:0]            rd;
    } ex_slot_t;

    // x0 and unused sources always read as zero, whatever the register file returns.
    function automatic logic [XLEN-1:0] src_operand(input logic            used,
                                                    input logic [4:0]      ad,
                                                    input logic [XLEN-1:0] data);
        return (used && ad != REG_ZERO) ? data : '0;
    endfunction

endpackage

// File: rtl/issue_slot.sv
// Single-entry valid/ready pipeline register for a decoded instruction,
// with flush and dequeue; accepts a new entry in the cycle the old one leaves.
module issue_slot
    import issue_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        deq_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  issue_slot_t in_data_i,
    output logic        valid_o,
    output issue_slot_t data_o
);

    logic        valid_q, valid_d;
    issue_slot_t data_q, data_d;
    logic        accept;

    assign in_ready_o = (!valid_q || deq_i) && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (deq_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the payload is reset too because its rd field is visible on a port out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/issue_stage.sv
// Operand-read and issue stage: reads sources, waits out reservations,
// reserves rd on issue and presents a registered slot to execute.
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int unsigned OP_W = ISSUE_OP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_rs1_v,
    input  logic             in_rs2_v,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic             in_rd_v,
    input  logic [4:0]       in_rd,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    output logic             r0_valid,
    output logic             r1_valid,
    output logic [4:0]       r0_ad,
    output logic [4:0]       r1_ad,
    input  logic [XLEN-1:0]  r0_data,
    input  logic [XLEN-1:0]  r1_data,
    input  logic             r_v,
    output logic             block_rd,
    output logic [4:0]       rd,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [OP_W-1:0]  ex_op,
    output logic [XLEN-1:0]  ex_a,
    output logic [XLEN-1:0]  ex_b,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_pc,
    output logic             ex_rd_v,
    output logic [4:0]       ex_rd,
    output logic [31:0]      stall_cnt
);

    issue_slot_t a_in, a_q;
    logic        a_valid;
    logic        issue, hazard;

    ex_slot_t    b_q, b_d;
    logic        b_valid_q, b_valid_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign a_in = '{op:    ISSUE_OP_W'(in_op),
                    rs1_v: in_rs1_v, rs1: in_rs1,
                    rs2_v: in_rs2_v, rs2: in_rs2,
                    rd_v:  in_rd_v,  rd:  in_rd,
                    imm:   in_imm,   pc:  in_pc};

    // Reset is folded into flush so nothing is accepted during the reset cycle.
    issue_slot u_slot_a (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush || rst),
        .deq_i      (issue),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (a_in),
        .valid_o    (a_valid),
        .data_o     (a_q)
    );

    assign r0_valid = a_valid && a_q.rs1_v;
    assign r1_valid = a_valid && a_q.rs2_v;
    assign r0_ad    = a_valid ? a_q.rs1 : REG_ZERO;
    assign r1_ad    = a_valid ? a_q.rs2 : REG_ZERO;

    assign hazard = a_valid && !r_v;
    assign issue  = a_valid && r_v && (!b_valid_q || ex_ready) && !flush && !rst;

    // The reservation lands with the capture into B, ahead of the next instruction's read.
    assign block_rd = issue && a_q.rd_v && (a_q.rd != REG_ZERO);
    assign rd       = a_q.rd;

    always_comb begin
        b_valid_d = b_valid_q;
        b_d       = b_q;
        if (flush) begin
            b_valid_d = 1'b0;
        end else if (issue) begin
            b_valid_d = 1'b1;
            b_d.op    = a_q.op;
            b_d.a     = src_operand(a_q.rs1_v, a_q.rs1, r0_data);
            b_d.b     = src_operand(a_q.rs2_v, a_q.rs2, r1_data);
            b_d.imm   = a_q.imm;
            b_d.pc    = a_q.pc;
            b_d.rd_v  = a_q.rd_v;
            b_d.rd    = a_q.rd;
        end else if (ex_ready && b_valid_q) begin
            b_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !flush && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid_q   <= 1'b0;
            b_q         <= '0;
            stall_cnt_q <= '0;
        end else begin
            b_valid_q   <= b_valid_d;
            b_q         <= b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid  = b_valid_q;
    assign ex_op     = OP_W'(b_q.op);
    assign ex_a      = b_q.a;
    assign ex_b      = b_q.b;
    assign ex_imm    = b_q.imm;
    assign ex_pc     = b_q.pc;
    assign ex_rd_v   = b_q.rd_v;
    assign ex_rd     = b_q.rd;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage with a small register-file/reservation model.
module tb_issue_stage;

    logic        clk, rst, flush;
    logic        in_valid, in_ready;
    logic [7:0]  in_op;
    logic        in_rs1_v, in_rs2_v, in_rd_v;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_imm, in_pc;
    logic        r0_valid, r1_valid;
    logic [4:0]  r0_ad, r1_ad;
    logic [31:0] r0_data, r1_data;
    logic        r_v, block_rd;
    logic [4:0]  rd;
    logic        ex_valid, ex_ready, ex_rd_v;
    logic [7:0]  ex_op;
    logic [31:0] ex_a, ex_b, ex_imm, ex_pc;
    logic [4:0]  ex_rd;
    logic [31:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Register file and reservation model.
    logic [31:0] regs [32];
    logic        busy [32];
    logic        clr_all, wb_v;
    logic [4:0]  wb_ad;
    logic [31:0] wb_data;

    issue_stage #(.OP_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1_v(in_rs1_v), .in_rs2_v(in_rs2_v), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rd_v(in_rd_v), .in_rd(in_rd), .in_imm(in_imm), .in_pc(in_pc),
        .r0_valid(r0_valid), .r1_valid(r1_valid), .r0_ad(r0_ad), .r1_ad(r1_ad),
        .r0_data(r0_data), .r1_data(r1_data), .r_v(r_v),
        .block_rd(block_rd), .rd(rd),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_rd_v(ex_rd_v), .ex_rd(ex_rd), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr_all) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == 0) ? 32'hDEAD_BEEF : (32'hA000_0000 | 32'(i));
                busy[i] <= 1'b0;
            end
        end else begin
            if (block_rd) busy[rd] <= 1'b1;
            if (wb_v) begin
                busy[wb_ad] <= 1'b0;
                regs[wb_ad] <= wb_data;
            end
        end
    end

    assign r0_data = regs[r0_ad];
    assign r1_data = regs[r1_ad];
    assign r_v     = !((r0_valid && busy[r0_ad]) || (r1_valid && busy[r1_ad]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] op, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic [31:0] imm, input logic [31:0] pc);
        in_valid = 1'b1; in_op = op;
        in_rs1_v = 1'b1; in_rs1 = s1;
        in_rs2_v = 1'b1; in_rs2 = s2;
        in_rd_v  = 1'b1; in_rd  = d;
        in_imm   = imm;  in_pc  = pc;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic model_clear();
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (ex_valid !== 1'b0 || stall_cnt !== 32'd0) begin n_bad++;
            $display("FAIL reset_ex: ex_valid=%b stall_cnt=%0d expected 0/0", ex_valid, stall_cnt); end
        n_cmp++; if (block_rd !== 1'b0 || rd !== 5'd0 || ex_a !== 32'd0 || ex_rd !== 5'd0) begin n_bad++;
            $display("FAIL reset_rsv: block_rd=%b rd=%0d ex_a=%h ex_rd=%0d expected all 0", block_rd, rd, ex_a, ex_rd); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || r0_valid !== 1'b0 || r1_valid !== 1'b0) begin n_bad++;
            $display("FAIL post_reset: in_ready=%b r0_valid=%b r1_valid=%b expected 1/0/0", in_ready, r0_valid, r1_valid); end
        tick();
    endtask

    task automatic test_independent();
        offer(8'h01, 5'd1, 5'd2, 5'd3, 32'h0000_0010, 32'h0000_1000);
        #1;
        n_cmp++; if (in_ready !== 1'b1 || ex_valid !== 1'b0) begin n_bad++;
            $display("FAIL indep_accept: in_ready=%b ex_valid=%b expected 1/0", in_ready, ex_valid); end
        tick();
        offer(8'h02, 5'd1, 5'd2, 5'd4, 32'h0000_0020, 32'h0000_1004);
        #1;
        n_cmp++; if (block_rd !== 1'b1 || rd !== 5'd3 || in_ready !== 1'b1) begin n_bad++;
            $display("FAIL indep_issue1: block_rd=%b rd=%0d in_ready=%b expected 1/3/1", block_rd, rd, in_ready); end
        n_cmp++; if (r0_valid !== 1'b1 || r0_ad !== 5'd1 || r1_valid !== 1'b1 || r1_ad !== 5'd2) begin n_bad++;
            $display("FAIL indep_reads: r0=%b/%0d r1=%b/%0d expected 1/1 1/2", r0_valid, r0_ad, r1_valid, r1_ad); end
        tick();
        idle();
        #1;
        n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_a !== 32'hA000_0001 || ex_b !== 32'hA000_0002) begin n_bad++;
            $display("FAIL indep_ex1: v=%b rd=%0d a=%h b=%h expected 1/3/a0000001/a0000002", ex_valid, ex_rd, ex_a, ex_b); end
        n_cmp++; if (ex_op !== 8'h01 || ex_imm !== 32'h10 || ex_pc !== 32'h1000 || ex_rd_v !== 1'b1) begin n_bad++;
            $display("FAIL indep_ex1_fields: op=%h imm=%h pc=%h rd_v=%b expected 01/10/1000/1", ex_op, ex_imm, ex_pc, ex_rd_v); end
        n_cmp++; if (block_rd !== 1'b1 || rd !== 5'd4) begin n_bad++;
            $display("FAIL indep_issue2: block_rd=%b rd=%0d expected 1/4", block_rd, rd); end
        tick();
        n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || ex_op !== 8'h02 || ex_pc !== 32'h1004) begin n_bad++;
            $display("FAIL indep_ex2: v=%b rd=%0d op=%h pc=%h expected 1/4/02/1004", ex_valid, ex_rd, ex_op, ex_pc); end
        n_cmp++; if (block_rd !== 1'b0 || stall_cnt !== 32'd0) begin n_bad++;
            $display("FAIL indep_tail: block_rd=%b stall_cnt=%0d expected 0/0", block_rd, stall_cnt); end
        tick();
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++;
            $display("FAIL indep_drain: ex_valid=%b expected 0", ex_valid); end
        model_clear();
    endtask

    task automatic test_raw();
        offer(8'h03, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0000_2000);
        tick();
        offer(8'h04, 5'd3, 5'd2, 5'd5, 32'h30, 32'h0000_2004);
        #1;
        n_cmp++; if (block_rd !== 1'b1 || rd !== 5'd3) begin n_bad++;
            $display("FAIL raw_producer: block_rd=%b rd=%0d expected 1/3", block_rd, rd); end
        tick();
        idle();
        #1;
        n_cmp++; if (in_ready !== 1'b0 || block_rd !== 1'b0 || r0_ad !== 5'd3) begin n_bad++;
            $display("FAIL raw_stall1: in_ready=%b block_rd=%b r0_ad=%0d expected 0/0/3", in_ready, block_rd, r0_ad); end
        tick();
        n_cmp++; if (in_ready !== 1'b0 || block_rd !== 1'b0) begin n_bad++;
            $display("FAIL raw_stall2: in_ready=%b block_rd=%b expected 0/0", in_ready, block_rd); end
        tick();
        wb_v = 1'b1; wb_ad = 5'd3; wb_data = 32'h1234_5678;
        tick();
        wb_v = 1'b0;
        #1;
        n_cmp++; if (block_rd !== 1'b1 || rd !== 5'd5 || stall_cnt !== 32'd3) begin n_bad++;
            $display("FAIL raw_release: block_rd=%b rd=%0d stall_cnt=%0d expected 1/5/3", block_rd, rd, stall_cnt); end
        tick();
        n_cmp++; if (ex_valid !== 1'b1 || ex_a !== 32'h1234_5678 || ex_b !== 32'hA000_0002 || ex_rd !== 5'd5) begin n_bad++;
            $display("FAIL raw_ex: v=%b a=%h b=%h rd=%0d expected 1/12345678/a0000002/5", ex_valid, ex_a, ex_b, ex_rd); end
        tick();
        model_clear();
    endtask

    task automatic test_x0();
        offer(8'h05, 5'd0, 5'd2, 5'd0, 32'h40, 32'h0000_3000);
        tick();
        idle();
        #1;
        n_cmp++; if (r0_valid !== 1'b1 || r0_ad !== 5'd0 || block_rd !== 1'b0) begin n_bad++;
            $display("FAIL x0_issue: r0_valid=%b r0_ad=%0d block_rd=%b expected 1/0/0", r0_valid, r0_ad, block_rd); end
        tick();
        n_cmp++; if (ex_valid !== 1'b1 || ex_a !== 32'd0 || ex_b !== 32'hA000_0002) begin n_bad++;
            $display("FAIL x0_ex: v=%b a=%h b=%h expected 1/00000000/a0000002", ex_valid, ex_a, ex_b); end
        n_cmp++; if (ex_rd !== 5'd0 || ex_rd_v !== 1'b1 || block_rd !== 1'b0) begin n_bad++;
            $display("FAIL x0_rd: ex_rd=%0d ex_rd_v=%b block_rd=%b expected 0/1/0", ex_rd, ex_rd_v, block_rd); end
        tick();
    endtask

    task automatic test_backpressure();
        ex_ready = 1'b0;
        offer(8'h06, 5'd1, 5'd2, 5'd6, 32'h50, 32'h0000_4000);
        tick();
        offer(8'h07, 5'd1, 5'd2, 5'd7, 32'h60, 32'h0000_4004);
        #1;
        n_cmp++; if (block_rd !== 1'b1 || rd !== 5'd6) begin n_bad++;
            $display("FAIL bp_first: block_rd=%b rd=%0d expected 1/6", block_rd, rd); end
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_op !== 8'h06 || block_rd !== 1'b0 || in_ready !== 1'b0) begin n_bad++;
                $display("FAIL bp_hold%0d: v=%b rd=%0d op=%h block_rd=%b in_ready=%b expected 1/6/06/0/0",
                         k, ex_valid, ex_rd, ex_op, block_rd, in_ready); end
            tick();
        end
        ex_ready = 1'b1;
        #1;
        n_cmp++; if (block_rd !== 1'b1 || rd !== 5'd7) begin n_bad++;
            $display("FAIL bp_release: block_rd=%b rd=%0d expected 1/7", block_rd, rd); end
        tick();
        n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || stall_cnt !== 32'd3) begin n_bad++;
            $display("FAIL bp_ex2: v=%b rd=%0d stall_cnt=%0d expected 1/7/3", ex_valid, ex_rd, stall_cnt); end
        tick();
        model_clear();
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        offer(8'h08, 5'd1, 5'd2, 5'd8, 32'h70, 32'h0000_5000);
        tick();
        offer(8'h09, 5'd8, 5'd2, 5'd9, 32'h80, 32'h0000_5004);
        tick();
        idle();
        #1;
        n_cmp++; if (in_ready !== 1'b0 || block_rd !== 1'b0 || ex_valid !== 1'b1) begin n_bad++;
            $display("FAIL fl_setup: in_ready=%b block_rd=%b ex_valid=%b expected 0/0/1", in_ready, block_rd, ex_valid); end
        tick();
        flush = 1'b1; ex_ready = 1'b1;
        offer(8'h0A, 5'd1, 5'd2, 5'd10, 32'h90, 32'h0000_5008);
        #1;
        n_cmp++; if (in_ready !== 1'b0 || block_rd !== 1'b0) begin n_bad++;
            $display("FAIL fl_cycle: in_ready=%b block_rd=%b expected 0/0", in_ready, block_rd); end
        tick();
        flush = 1'b0;
        idle();
        #1;
        n_cmp++; if (ex_valid !== 1'b0 || r0_valid !== 1'b0 || r1_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++;
            $display("FAIL fl_after: ex_valid=%b r0_valid=%b r1_valid=%b in_ready=%b expected 0/0/0/1",
                     ex_valid, r0_valid, r1_valid, in_ready); end
        n_cmp++; if (stall_cnt !== 32'd4) begin n_bad++;
            $display("FAIL fl_stall_cnt: got %0d expected 4", stall_cnt); end
        tick();
        model_clear();
    endtask

    task automatic test_reset_mid();
        ex_ready = 1'b1;
        offer(8'h0B, 5'd1, 5'd2, 5'd10, 32'hA0, 32'h0000_6000);
        tick();
        offer(8'h0C, 5'd10, 5'd2, 5'd11, 32'hB0, 32'h0000_6004);
        tick();
        idle();
        #1;
        n_cmp++; if (in_ready !== 1'b0 || block_rd !== 1'b0) begin n_bad++;
            $display("FAIL rm_stall: in_ready=%b block_rd=%b expected 0/0", in_ready, block_rd); end
        tick();
        tick();
        wb_v = 1'b1; wb_ad = 5'd10; wb_data = 32'h0000_00AA;
        tick();
        wb_v = 1'b0;
        #1;
        n_cmp++; if (stall_cnt !== 32'd7) begin n_bad++;
            $display("FAIL rm_pre_cnt: got %0d expected 7", stall_cnt); end
        rst = 1'b1;
        #1;
        n_cmp++; if (block_rd !== 1'b0 || in_ready !== 1'b0) begin n_bad++;
            $display("FAIL rm_rst_cycle: block_rd=%b in_ready=%b expected 0/0", block_rd, in_ready); end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (ex_valid !== 1'b0 || ex_op !== 8'h00 || ex_a !== 32'd0 || ex_b !== 32'd0 || ex_imm !== 32'd0
                     || ex_pc !== 32'd0 || ex_rd_v !== 1'b0 || ex_rd !== 5'd0) begin n_bad++;
            $display("FAIL rm_ex_zero: v=%b op=%h a=%h b=%h imm=%h pc=%h rd_v=%b rd=%0d expected all 0",
                     ex_valid, ex_op, ex_a, ex_b, ex_imm, ex_pc, ex_rd_v, ex_rd); end
        n_cmp++; if (stall_cnt !== 32'd0 || r0_valid !== 1'b0 || r1_valid !== 1'b0 || rd !== 5'd0) begin n_bad++;
            $display("FAIL rm_state: stall_cnt=%0d r0_valid=%b r1_valid=%b rd=%0d expected 0/0/0/0",
                     stall_cnt, r0_valid, r1_valid, rd); end
        tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        in_valid = 1'b0; in_op = '0;
        in_rs1_v = 1'b0; in_rs2_v = 1'b0; in_rd_v = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0; in_pc = '0;
        clr_all = 1'b1; wb_v = 1'b0; wb_ad = '0; wb_data = '0;
        tick();
        tick();
        clr_all = 1'b0;
        test_reset();
        test_independent();
        test_raw();
        test_x0();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

endmodule
